axi_rd_arbiter: RTL and testbench

AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

---
 rtl/axi_rd_arbiter.sv | 147 ++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: two-requester round-robin AXI read arbiter, one burst in flight; define AXI_RD_ARB_PERF_EN for per-requester grant counters
module axi_rd_arbiter #(
    parameter int ID_W   = 5,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              s0_arvalid,
    output logic              s0_arready,
    input  logic [ID_W-1:0]   s0_arid,
    input  logic [ADDR_W-1:0] s0_araddr,
    input  logic [7:0]        s0_arlen,
    input  logic [2:0]        s0_arsize,
    input  logic [1:0]        s0_arburst,
    output logic              s0_rvalid,
    input  logic              s0_rready,
    output logic [ID_W-1:0]   s0_rid,
    output logic [DATA_W-1:0] s0_rdata,
    output logic [1:0]        s0_rresp,
    output logic              s0_rlast,
    input  logic              s1_arvalid,
    output logic              s1_arready,
    input  logic [ID_W-1:0]   s1_arid,
    input  logic [ADDR_W-1:0] s1_araddr,
    input  logic [7:0]        s1_arlen,
    input  logic [2:0]        s1_arsize,
    input  logic [1:0]        s1_arburst,
    output logic              s1_rvalid,
    input  logic              s1_rready,
    output logic [ID_W-1:0]   s1_rid,
    output logic [DATA_W-1:0] s1_rdata,
    output logic [1:0]        s1_rresp,
    output logic              s1_rlast,
    output logic              m_arvalid,
    input  logic              m_arready,
    output logic [ID_W-1:0]   m_arid,
    output logic [ADDR_W-1:0] m_araddr,
    output logic [7:0]        m_arlen,
    output logic [2:0]        m_arsize,
    output logic [1:0]        m_arburst,
    input  logic              m_rvalid,
    output logic              m_rready,
    input  logic [ID_W-1:0]   m_rid,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rlast
`ifdef AXI_RD_ARB_PERF_EN
    ,
    output logic [31:0]       gnt_cnt0,
    output logic [31:0]       gnt_cnt1
`endif
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
    state_t state_q, state_d;
    logic last_q, last_d, owner_q, owner_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0] len_q, len_d;
    logic [2:0] size_q, size_d;
    logic [1:0] burst_q, burst_d;
    logic grant, pick;
    always_comb begin
        // pick is the requester index: the one not granted last under contention
        pick = (s0_arvalid && s1_arvalid) ? !last_q : s1_arvalid;
        grant = (state_q == IDLE) && !reset && (s0_arvalid || s1_arvalid);
        state_d = state_q;
        last_d = last_q;
        owner_d = owner_q;
        id_d = id_q;
        addr_d = addr_q;
        len_d = len_q;
        size_d = size_q;
        burst_d = burst_q;
        if (grant) begin
            state_d = ADDR;
            last_d = pick;
            owner_d = pick;
            id_d = pick ? s1_arid : s0_arid;
            addr_d = pick ? s1_araddr : s0_araddr;
            len_d = pick ? s1_arlen : s0_arlen;
            size_d = pick ? s1_arsize : s0_arsize;
            burst_d = pick ? s1_arburst : s0_arburst;
        end
        if (state_q == ADDR && m_arready) state_d = DATA;
        if (state_q == DATA && m_rvalid && m_rready && m_rlast) state_d = IDLE;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            last_q <= 1'b1;
            owner_q <= 1'b0;
            id_q <= '0;
            addr_q <= '0;
            len_q <= '0;
            size_q <= '0;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            last_q <= last_d;
            owner_q <= owner_d;
            id_q <= id_d;
            addr_q <= addr_d;
            len_q <= len_d;
            size_q <= size_d;
            burst_q <= burst_d;
        end
    end
    assign s0_arready = grant && !pick;
    assign s1_arready = grant && pick;
    assign m_arvalid = state_q == ADDR;
    assign m_arid = id_q;
    assign m_araddr = addr_q;
    assign m_arlen = len_q;
    assign m_arsize = size_q;
    assign m_arburst = burst_q;
    assign m_rready = (state_q == DATA) && (owner_q ? s1_rready : s0_rready);
    // R payload is broadcast; only the owner's rvalid qualifies it
    assign s0_rvalid = (state_q == DATA) && !owner_q && m_rvalid;
    assign s1_rvalid = (state_q == DATA) && owner_q && m_rvalid;
    assign s0_rid = m_rid;
    assign s0_rdata = m_rdata;
    assign s0_rresp = m_rresp;
    assign s0_rlast = m_rlast;
    assign s1_rid = m_rid;
    assign s1_rdata = m_rdata;
    assign s1_rresp = m_rresp;
    assign s1_rlast = m_rlast;
`ifdef AXI_RD_ARB_PERF_EN
    logic [31:0] gnt_cnt0_q, gnt_cnt0_d, gnt_cnt1_q, gnt_cnt1_d;
    always_comb begin
        gnt_cnt0_d = gnt_cnt0_q + 32'(s0_arready);
        gnt_cnt1_d = gnt_cnt1_q + 32'(s1_arready);
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            gnt_cnt0_q <= '0;
            gnt_cnt1_q <= '0;
        end else begin
            gnt_cnt0_q <= gnt_cnt0_d;
            gnt_cnt1_q <= gnt_cnt1_d;
        end
    end
    assign gnt_cnt0 = gnt_cnt0_q;
    assign gnt_cnt1 = gnt_cnt1_q;
`endif
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: random requesters and memory agent checked against a transaction-level round-robin model
module tb_axi_rd_arbiter;
    localparam int ID_W = 5;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [1:0] arvalid, arready, rvalid, rready, rlast;
    logic [1:0][ID_W-1:0] arid, rid;
    logic [1:0][ADDR_W-1:0] araddr;
    logic [1:0][7:0] arlen;
    logic [1:0][2:0] arsize;
    logic [1:0][1:0] arburst, rresp;
    logic [1:0][DATA_W-1:0] rdata;
    logic m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
    logic [ID_W-1:0] m_arid, m_rid;
    logic [ADDR_W-1:0] m_araddr;
    logic [7:0] m_arlen;
    logic [2:0] m_arsize;
    logic [1:0] m_arburst, m_rresp;
    logic [DATA_W-1:0] m_rdata;
`ifdef AXI_RD_ARB_PERF_EN
    logic [31:0] gnt_cnt0, gnt_cnt1;
`endif

    axi_rd_arbiter #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clock(clock), .reset(reset),
        .s0_arvalid(arvalid[0]), .s0_arready(arready[0]), .s0_arid(arid[0]), .s0_araddr(araddr[0]),
        .s0_arlen(arlen[0]), .s0_arsize(arsize[0]), .s0_arburst(arburst[0]),
        .s0_rvalid(rvalid[0]), .s0_rready(rready[0]), .s0_rid(rid[0]), .s0_rdata(rdata[0]),
        .s0_rresp(rresp[0]), .s0_rlast(rlast[0]),
        .s1_arvalid(arvalid[1]), .s1_arready(arready[1]), .s1_arid(arid[1]), .s1_araddr(araddr[1]),
        .s1_arlen(arlen[1]), .s1_arsize(arsize[1]), .s1_arburst(arburst[1]),
        .s1_rvalid(rvalid[1]), .s1_rready(rready[1]), .s1_rid(rid[1]), .s1_rdata(rdata[1]),
        .s1_rresp(rresp[1]), .s1_rlast(rlast[1]),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid), .m_araddr(m_araddr),
        .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid), .m_rdata(m_rdata),
        .m_rresp(m_rresp), .m_rlast(m_rlast)
`ifdef AXI_RD_ARB_PERF_EN
        , .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
`endif
    );

    initial forever #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    // agents and knobs
    logic [1:0] pend;
    bit gen_on, rst_req, drop_arm;
    int p_req, p_ar, p_rv, p_rr, max_len, ar_hold, hold1, rst_beat;
    bit mem_busy;
    logic [ID_W-1:0] mem_id;
    logic [ADDR_W-1:0] mem_addr;
    int mem_len, mem_beat;
    int rcv_last[2], rcv_beats[2], exp_done[2];
    int dut_g[$];
    // reference model: current burst owner (-1 = none) and its request
    int own, lastg, k;
    bit ar_done;
    logic [ID_W-1:0] g_id;
    logic [ADDR_W-1:0] g_addr;
    logic [7:0] g_len;
    logic [2:0] g_size;
    logic [1:0] g_burst;
    int gcnt[2];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] beat_data(input logic [31:0] a, input int b);
        return {a ^ 32'h5a5a_0000, 32'(b) * 32'h0101_0101};
    endfunction

    task automatic step();
        bit do_rst;
        int w;
        do_rst = rst_req;
        rst_req = 0;
        @(posedge clock);
        #1;
        reset = do_rst;
        for (int i = 0; i < 2; i++) begin
            if (!pend[i] && gen_on && $urandom_range(99) < p_req) begin
                pend[i] = 1'b1;
                arid[i] = ID_W'($urandom);
                araddr[i] = $urandom;
                arlen[i] = 8'($urandom_range(max_len));
                arsize[i] = 3'($urandom);
                arburst[i] = 2'($urandom);
            end
            arvalid[i] = pend[i] && !do_rst;
            rready[i] = !do_rst && ($urandom_range(99) < p_rr) && !(i == 1 && hold1 > 0);
        end
        if (hold1 > 0) hold1--;
        m_arready = !do_rst && ar_hold == 0 && $urandom_range(99) < p_ar;
        if (ar_hold > 0 && m_arvalid) ar_hold--;
        if (mem_busy) begin
            m_rvalid = !do_rst && $urandom_range(99) < p_rv;
            m_rid = mem_id;
            m_rdata = beat_data(mem_addr, mem_beat);
            m_rresp = 2'(mem_beat);
            m_rlast = mem_beat == mem_len;
        end else begin
            m_rvalid = !do_rst && $urandom_range(99) < 30;
            m_rid = ID_W'($urandom);
            m_rdata = {$urandom, $urandom};
            m_rresp = 2'($urandom);
            m_rlast = 1'b1;
        end
        @(negedge clock);
        if (do_rst) begin
            own = -1; lastg = 1; k = 0; ar_done = 0;
            gcnt[0] = 0; gcnt[1] = 0;
            pend = '0; mem_busy = 0; hold1 = 0; ar_hold = 0;
            return;
        end
        for (int i = 0; i < 2; i++) begin
            if (arready[i]) dut_g.push_back(i);
            if (rvalid[i] && rready[i]) rcv_beats[i]++;
            if (rvalid[i] && rready[i] && rlast[i]) rcv_last[i]++;
        end
`ifdef AXI_RD_ARB_PERF_EN
        check("gnt_cnt0", gnt_cnt0, 64'(gcnt[0]));
        check("gnt_cnt1", gnt_cnt1, 64'(gcnt[1]));
`endif
        if (own < 0) begin
            check("idle_m_arvalid", m_arvalid, 0);
            check("idle_m_rready", m_rready, 0);
            check("idle_rvalid", rvalid, 0);
            if (arvalid != 2'b00) begin
                w = (arvalid == 2'b11) ? 1 - lastg : (arvalid[1] ? 1 : 0);
                check("grant", arready, 64'(2'b01) << w);
                own = w; lastg = w; k = 0; ar_done = 0; gcnt[w]++;
                g_id = arid[w]; g_addr = araddr[w]; g_len = arlen[w];
                g_size = arsize[w]; g_burst = arburst[w];
            end else check("idle_arready", arready, 0);
        end else if (!ar_done) begin
            check("addr_arready", arready, 0);
            check("m_arvalid", m_arvalid, 1);
            check("m_ar_fields", {m_arid, m_araddr, m_arlen, m_arsize, m_arburst},
                  {g_id, g_addr, g_len, g_size, g_burst});
            check("addr_m_rready", m_rready, 0);
            check("addr_rvalid", rvalid, 0);
            if (m_arready) ar_done = 1;
        end else begin
            check("data_arready", arready, 0);
            check("data_m_arvalid", m_arvalid, 0);
            check("m_rready", m_rready, rready[own]);
            check("owner_rvalid", rvalid[own], m_rvalid);
            check("other_rvalid", rvalid[1-own], 0);
            if (m_rvalid && rready[own]) begin
                check("rbeat", {rid[own], rresp[own], rlast[own]}, {g_id, 2'(k), k == int'(g_len)});
                check("rdata", rdata[own], beat_data(g_addr, k));
                if (k == int'(g_len)) begin
                    exp_done[own]++;
                    own = -1;
                end else k++;
            end
        end
        for (int i = 0; i < 2; i++) if (arvalid[i] && arready[i]) pend[i] = 1'b0;
        if (!mem_busy && m_arvalid && m_arready) begin
            mem_busy = 1; mem_id = m_arid; mem_addr = m_araddr; mem_len = int'(m_arlen); mem_beat = 0;
        end else if (mem_busy && m_rvalid && m_rready) begin
            if (mem_beat == mem_len) mem_busy = 0;
            else mem_beat++;
        end
        if (drop_arm && own == 1 && ar_done && k == 1) begin
            hold1 = 3;
            drop_arm = 0;
        end
        if (rst_beat >= 0 && own >= 0 && ar_done && k == rst_beat) begin
            rst_req = 1;
            rst_beat = -1;
        end
    endtask

    task automatic drain(input int n);
        int c = 0;
        while ((own >= 0 || pend != 2'b00 || rst_req) && c < n) begin
            step();
            c++;
        end
        if (c >= n) check("drain_timeout", 64'(c), 64'(0));
    endtask

    task automatic do_reset();
        rst_req = 1;
        step();
        step();
    endtask

    task automatic set_req(input int i, input logic [ID_W-1:0] id, input logic [31:0] a, input logic [7:0] l);
        pend[i] = 1'b1; arid[i] = id; araddr[i] = a; arlen[i] = l;
        arsize[i] = 3'd3; arburst[i] = 2'd1;
    endtask

    initial begin
        arvalid = '0; rready = '0; arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
        m_arready = 0; m_rvalid = 0; m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 0;
        pend = '0; gen_on = 0; drop_arm = 0; rst_beat = -1; hold1 = 0; ar_hold = 0;
        p_req = 100; p_ar = 100; p_rv = 100; p_rr = 100; max_len = 3;
        own = -1; lastg = 1; k = 0; ar_done = 0; mem_busy = 0;
        for (int i = 0; i < 2; i++) begin rcv_last[i] = 0; rcv_beats[i] = 0; exp_done[i] = 0; gcnt[i] = 0; end
        do_reset();
        check("rst_outputs", {arready, rvalid, m_arvalid, m_rready}, 0);
`ifdef AXI_RD_ARB_PERF_EN
        check("rst_gnt_cnt", {gnt_cnt0, gnt_cnt1}, 0);
`endif
        // s0 alone, 4-beat burst
        set_req(0, 5'd2, 32'h8000_1000, 8'd3);
        drain(40);
        check("s0_beats", 64'(rcv_beats[0]), 4);
        check("s0_bursts", 64'(rcv_last[0]), 1);
        // contention right after reset: s0 first, then alternation
        do_reset();
        dut_g.delete();
        gen_on = 1; max_len = 2;
        for (int c = 0; c < 200 && dut_g.size() < 4; c++) step();
        gen_on = 0;
        drain(60);
        check("rr_grants", 64'(dut_g.size() >= 4), 1);
        for (int j = 0; j < 4 && j < dut_g.size(); j++) check("rr_order", 64'(dut_g[j]), 64'(j % 2));
        // m_arready held off while s1 waits
        do_reset();
        dut_g.delete();
        set_req(0, ID_W'($urandom), $urandom, 8'd2);
        set_req(1, ID_W'($urandom), $urandom, 8'd1);
        ar_hold = 5;
        drain(60);
        check("hold_grants", 64'(dut_g.size()), 2);
        check("hold_order", {dut_g[0] == 0, dut_g[1] == 1}, 2'b11);
        // s1 owner stalls rready mid-burst
        rcv_beats[1] = 0;
        set_req(1, ID_W'($urandom), $urandom, 8'd7);
        drop_arm = 1;
        drain(60);
        check("stall_beats", 64'(rcv_beats[1]), 8);
        // three grants to s0, reset during the third burst
        do_reset();
        set_req(0, ID_W'($urandom), $urandom, 8'd0);
        drain(20);
        set_req(0, ID_W'($urandom), $urandom, 8'd1);
        drain(20);
        set_req(0, ID_W'($urandom), $urandom, 8'd3);
        rst_beat = 1;
        drain(40);
        step();
        check("post_rst", {arready, rvalid, m_arvalid, m_rready}, 0);
`ifdef AXI_RD_ARB_PERF_EN
        check("post_rst_gnt_cnt0", gnt_cnt0, 0);
`endif
        // random traffic
        gen_on = 1; p_req = 40; p_ar = 60; p_rv = 70; p_rr = 70; max_len = 7;
        repeat (3000) step();
        gen_on = 0;
        drain(500);
        check("done_s0", 64'(rcv_last[0]), 64'(exp_done[0]));
        check("done_s1", 64'(rcv_last[1]), 64'(exp_done[1]));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
